// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - N-channel synchronised, debounced edge detector with sticky pending flags
// Each channel: sync chain -> stability filter -> registered rise/fall/qualified pulses.
module multi_edge_detector #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     level_i,
  input  logic [2*NUM_CH-1:0]   mode_i,
  input  logic [NUM_CH-1:0]     clr_i,
  output logic [NUM_CH-1:0]     level_o,
  output logic [NUM_CH-1:0]     p_edge_o,
  output logic [NUM_CH-1:0]     n_edge_o,
  output logic [NUM_CH-1:0]     any_edge_o,
  output logic [NUM_CH-1:0]     pending_o,
  output logic                  irq_o
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] differ;
  logic [NUM_CH-1:0] accepted;
  logic [NUM_CH-1:0] any_next;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // level_o doubles as the filter's stable register.
  always_comb begin
    differ   = '0;
    accepted = '0;
    any_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      differ[i]   = sync_out[i] ^ level_o[i];
      accepted[i] = differ[i] && (cnt_q[i] == CNT_LAST);
      any_next[i] = accepted[i] & (sync_out[i] ? mode_i[2*i] : mode_i[2*i+1]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      level_o    <= '0;
      p_edge_o   <= '0;
      n_edge_o   <= '0;
      any_edge_o <= '0;
      pending_o  <= '0;
    end else begin
      sync_q[0] <= level_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < NUM_CH; i++) begin
        if (!differ[i] || accepted[i]) cnt_q[i] <= '0;
        else                           cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
      level_o    <= level_o ^ accepted;
      p_edge_o   <= accepted & sync_out;
      n_edge_o   <= accepted & ~sync_out;
      any_edge_o <= any_next;
      // A same-cycle set overrides the clear.
      pending_o  <= (pending_o & ~clr_i) | any_next;
    end
  end

  assign irq_o = |pending_o;

endmodule
